donkey_ctl: RTL
===============

Name: donkey_ctl

Overview:
- Per-frame motion controller for the Donkey sprite; drives the position and orientation inputs of the Donkey draw stage directly.
- Consumes the keyboard key code and the VGA vertical-blank signal.
- Updates position once per frame, at the rising edge of vblnk. Outputs therefore stay constant throughout active video.
- Implements horizontal walking with screen clamping and a jump/fall state machine with gravity.

Parameters:
- X_START, 100, reset x position (pixels)
- Y_GROUND, 640, y of sprite top when standing on floor
- X_MIN, 0, leftmost allowed xpos
- X_MAX, 960, rightmost allowed xpos (1024 - DONKEY_WIDTH)
- STEP_X, 2, horizontal pixels per frame while A/D held
- JUMP_V0, 12, initial upward velocity (pixels/frame)
- V_MAX, 15, terminal fall velocity (pixels/frame)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- vblnk  in  1  vertical blank from the VGA timing chain
- keyCode  in  16  current key code from the keyboard block (A, D, W from keyboard_pkg; 0 = none)
- xpos  out  12  sprite left edge
- ypos  out  12  sprite top edge
- left  out  1  current key is A
- previous  out  16  last non-zero key code
- state_o  out  2  FSM state (debug): 0 GROUND, 1 RISE, 2 FALL

Behaviour:
- Single clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - xpos=X_START, ypos=Y_GROUND, left=0, previous=0, state=GROUND.
  - Internal: vel=0, vblnk_q=0.
- Tick generation:
  - vblnk_q registers vblnk every cycle; tick = vblnk & ~vblnk_q.
  - Exactly one tick per frame.
  - All outputs change only on the clock edge where tick is high, so updated values are visible 1 cycle after vblnk is first sampled high.
  - Between ticks all outputs hold.
- Key sampling (on tick only):
  - left <= (keyCode==A).
  - If keyCode!=0, previous <= keyCode; otherwise previous holds.
- Horizontal motion (on tick, in every state):
  - A: xpos <= max(X_MIN, xpos-STEP_X).
  - D: xpos <= min(X_MAX, xpos+STEP_X).
  - Any other key: hold.
  - Compute in 13-bit signed arithmetic so xpos never wraps below 0.
- Vertical FSM (evaluated on tick; vel is an unsigned 5-bit register):
  - GROUND:
    - If keyCode==W: state<=RISE, vel<=JUMP_V0, ypos unchanged this tick.
    - Otherwise stay; ypos held at Y_GROUND.
  - RISE:
    - ypos <= ypos - vel; vel <= vel - 1.
    - When vel==1 on this tick: state<=FALL, vel<=0.
  - FALL:
    - If ypos+vel >= Y_GROUND: ypos<=Y_GROUND, vel<=0, state<=GROUND.
    - Else: ypos<=ypos+vel, vel<=min(vel+1, V_MAX).
- Peak height: a jump with JUMP_V0=12 rises 78 px (12+11+...+1) over 12 ticks. Apex is ypos = Y_GROUND-78 = 562.
- Boundaries:
  - ypos never exceeds Y_GROUND.
  - W held during RISE/FALL has no effect (base build).
  - Key release mid-jump keeps the vertical trajectory.
  - A held with xpos=X_MIN+1 clamps to X_MIN.
- Reset asserted mid-jump returns to the reset values on the next edge; the first tick after reset release behaves as GROUND.
- If vblnk is stuck high there is no further tick and no motion.

Optional Feature:
- Macro: DONKEY_DOUBLE_JUMP_EN.
- Enabled:
  - Add a 1-bit used_dj flag (reset 0; cleared on entering GROUND) and a w_q register holding (keyCode==W) sampled each tick.
  - In RISE or FALL, a tick with keyCode==W and w_q==0 and used_dj==0 does the following: state<=RISE, vel<=JUMP_V0, used_dj<=1, ypos unchanged that tick.
- Disabled: no flag or registers; W is ignored while airborne.

Test Plan:
- Reset then idle: rst 2 cycles, 5 vblnk pulses with keyCode=0 -> xpos=100, ypos=640, left=0, previous=0, state_o=0.
- Walk left with clamp: keyCode=A for 60 ticks -> xpos decrements by 2 per tick, reaches 0 at tick 50 and stays 0. left=1, previous=A. Outputs change only on the cycle after the vblnk rising edge.
- Walk right with clamp: start xpos=100, keyCode=D for 500 ticks -> xpos saturates at 960. left=0, previous=D. Release key -> previous stays D.
- Full jump: keyCode=W for 1 tick then 0 -> state 0→1.
  - Apex ypos=562 after 12 RISE ticks, then FALL.
  - Lands with ypos exactly 640 and state 0; ypos never exceeds 640.
- Reset mid-jump: assert rst at ypos=600 during RISE -> next cycle ypos=640, xpos=100, state_o=0, vel=0.
- (DONKEY_DOUBLE_JUMP_EN) In FALL, press W on a new tick -> vel reloads to 12 and state goes to RISE. A second fresh W before landing is ignored. After landing, W jumps again.

Source files
------------

// File: rtl/donkey_ctl.sv
// donkey_ctl: per-frame motion controller for the Donkey sprite.
// The controller makes one position update per frame, at the rising edge of vblnk. Between
// updates every output holds, so the draw stage sees fixed values during active video.
//
// Ports:
//   clk      in   pixel clock
//   rst      in   synchronous, active-high reset
//   vblnk    in   vertical blank from the VGA timing chain
//   keyCode  in   [15:0] current key code (KEY_A / KEY_D / KEY_W, 0 = none)
//   xpos     out  [11:0] sprite left edge
//   ypos     out  [11:0] sprite top edge
//   left     out  current key is A (sprite faces left)
//   previous out  [15:0] last non-zero key code
//   state_o  out  [1:0] vertical FSM state: 0 ground, 1 rise, 2 fall
//
// Optional build macro: DONKEY_DOUBLE_JUMP_EN enables a single mid-air jump per airtime, which a
// fresh W press triggers.

module donkey_ctl #(
  parameter int unsigned X_START  = 100,
  parameter int unsigned Y_GROUND = 640,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 960,
  parameter int unsigned STEP_X   = 2,
  parameter int unsigned JUMP_V0  = 12,
  parameter int unsigned V_MAX    = 15,
  parameter logic [15:0] KEY_A    = 16'h001C,
  parameter logic [15:0] KEY_D    = 16'h0023,
  parameter logic [15:0] KEY_W    = 16'h001D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [15:0] keyCode,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left,
  output logic [15:0] previous,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    StGround = 2'd0,
    StRise   = 2'd1,
    StFall   = 2'd2
  } state_e;

  localparam logic signed [12:0] XMinS  = 13'(X_MIN);
  localparam logic signed [12:0] XMaxS  = 13'(X_MAX);
  localparam logic signed [12:0] XStepS = 13'(STEP_X);
  localparam logic [11:0]        YGnd   = 12'(Y_GROUND);
  localparam logic [4:0]         VJump  = 5'(JUMP_V0);
  localparam logic [4:0]         VMax   = 5'(V_MAX);

  state_e      state_q, state_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic [4:0]  vel_q, vel_d;
  logic        left_q, left_d;
  logic [15:0] prev_q, prev_d;
  logic        vblnk_q;
  logic        tick;
  logic        key_a, key_d, key_w;

  logic signed [12:0] x_ext, x_dec, x_inc;
  logic [11:0]        y_up;
  logic [12:0]        y_dn;

`ifdef DONKEY_DOUBLE_JUMP_EN
  logic used_dj_q, used_dj_d;
  logic w_q, w_d;
`endif

  assign tick  = vblnk & ~vblnk_q;
  assign key_a = (keyCode == KEY_A);
  assign key_d = (keyCode == KEY_D);
  assign key_w = (keyCode == KEY_W);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StGround;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      xpos_q  <= 12'(X_START);
      ypos_q  <= YGnd;
      vel_q   <= 5'd0;
      left_q  <= 1'b0;
      prev_q  <= 16'd0;
    end else begin
      vblnk_q <= vblnk;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      vel_q   <= vel_d;
      left_q  <= left_d;
      prev_q  <= prev_d;
    end
  end

`ifdef DONKEY_DOUBLE_JUMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      used_dj_q <= 1'b0;
      w_q       <= 1'b0;
    end else begin
      used_dj_q <= used_dj_d;
      w_q       <= w_d;
    end
  end
`endif

  // Next-state and datapath update; everything holds unless this is the frame tick.
  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    vel_d   = vel_q;
    left_d  = left_q;
    prev_d  = prev_q;
`ifdef DONKEY_DOUBLE_JUMP_EN
    used_dj_d = used_dj_q;
    w_d       = w_q;
`endif

    // Signed 13-bit so a step below zero compares as negative instead of wrapping.
    x_ext = $signed({1'b0, xpos_q});
    x_dec = x_ext - XStepS;
    x_inc = x_ext + XStepS;
    y_up  = ypos_q - {7'd0, vel_q};
    y_dn  = {1'b0, ypos_q} + {8'd0, vel_q};

    if (tick) begin
      left_d = key_a;
      if (keyCode != 16'd0) prev_d = keyCode;

      if (key_a) begin
        xpos_d = (x_dec < XMinS) ? 12'(X_MIN) : x_dec[11:0];
      end else if (key_d) begin
        xpos_d = (x_inc > XMaxS) ? 12'(X_MAX) : x_inc[11:0];
      end

      unique case (state_q)
        StGround: begin
          ypos_d = YGnd;
          if (key_w) begin
            state_d = StRise;
            vel_d   = VJump;
          end
        end
        StRise: begin
          ypos_d = y_up;
          if (vel_q <= 5'd1) begin
            state_d = StFall;
            vel_d   = 5'd0;
          end else begin
            vel_d = vel_q - 5'd1;
          end
        end
        StFall: begin
          if (y_dn >= 13'(Y_GROUND)) begin
            ypos_d  = YGnd;
            vel_d   = 5'd0;
            state_d = StGround;
          end else begin
            ypos_d = y_dn[11:0];
            vel_d  = (vel_q >= VMax) ? VMax : vel_q + 5'd1;
          end
        end
        default: state_d = StGround;
      endcase

`ifdef DONKEY_DOUBLE_JUMP_EN
      // Only a fresh W edge triggers a mid-air jump, so holding W cannot retrigger it.
      if (state_q != StGround && key_w && !w_q && !used_dj_q) begin
        state_d   = StRise;
        vel_d     = VJump;
        ypos_d    = ypos_q;
        used_dj_d = 1'b1;
      end
      if (state_d == StGround) used_dj_d = 1'b0;
      w_d = key_w;
`endif
    end
  end

  // Outputs
  always_comb begin
    xpos     = xpos_q;
    ypos     = ypos_q;
    left     = left_q;
    previous = prev_q;
    state_o  = state_q;
  end

endmodule
